// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). One transaction is in flight at a time. A transaction is accepted in
// IDLE, presented to memory in REQ, and completed in WAIT. Every wait is bounded by a timeout
// that returns an error response to the requester.
//
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   ifu_req_valid_i/_ready_o     IFU request handshake; ifu_addr_i is the fetch address
//   ifu_resp_valid_o             one-cycle IFU response strobe; qualifies ifu_rdata_o and
//                                ifu_resp_err_o
//   lsu_req_valid_i/_ready_o     LSU request handshake; lsu_addr_i, lsu_wen_i, lsu_wdata_i and
//                                lsu_wmask_i carry the request
//   lsu_resp_valid_o             one-cycle LSU response strobe, also for stores; qualifies
//                                lsu_rdata_o and lsu_resp_err_o
//   mem_req_valid_o/_ready_i     memory request handshake; mem_addr_o, mem_wen_o, mem_wdata_o and
//                                mem_wmask_o hold the fields latched at grant
//   mem_resp_valid_i, mem_rdata_i  memory response
//   arb_timeout_o                one-cycle pulse when a transaction is ended by the timeout
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned LSU_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // IFU side
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic                ifu_resp_err_o,
    // LSU side
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_resp_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_resp_err_o,
    // Memory side
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                arb_timeout_o
);

    localparam int unsigned MaskW = DATA_W / 8;
    localparam int unsigned CntW  = $clog2(TIMEOUT + 1);
    localparam int unsigned StrW  = $clog2(LSU_STREAK + 1);

    // The counter holds the number of REQ/WAIT cycles already completed, so the TIMEOUT-th
    // cycle is the one that sees TIMEOUT-1.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [StrW-1:0] StrMax  = StrW'(LSU_STREAK);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;     // 0 = IFU, 1 = LSU
    logic [StrW-1:0]   streak_q, streak_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MaskW-1:0]  wmask_q, wmask_d;

    logic              ifu_win, lsu_win;
    logic              resp_fire, resp_err;
    logic [DATA_W-1:0] resp_data;

    // LSU has priority unless it has already used its streak while IFU was waiting.
    always_comb begin
        ifu_win = ifu_req_valid_i && (!lsu_req_valid_i || (streak_q == StrMax));
        lsu_win = lsu_req_valid_i && !ifu_win;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;

        ifu_req_ready_o = 1'b0;
        lsu_req_ready_o = 1'b0;
        mem_req_valid_o = 1'b0;
        arb_timeout_o   = 1'b0;
        resp_fire       = 1'b0;
        resp_err        = 1'b0;
        resp_data       = '0;

        unique case (state_q)
            StIdle: begin
                ifu_req_ready_o = ifu_win;
                lsu_req_ready_o = lsu_win;
                if (ifu_win) begin
                    state_d  = StReq;
                    owner_d  = 1'b0;
                    streak_d = '0;
                    cnt_d    = '0;
                    addr_d   = ifu_addr_i;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                end else if (lsu_win) begin
                    state_d = StReq;
                    owner_d = 1'b1;
                    cnt_d   = '0;
                    addr_d  = lsu_addr_i;
                    wen_d   = lsu_wen_i;
                    wdata_d = lsu_wdata_i;
                    wmask_d = lsu_wmask_i;
                    // Only grants that make a pending IFU wait count toward the streak.
                    if (ifu_req_valid_i && (streak_q != StrMax)) begin
                        streak_d = streak_q + StrW'(1);
                    end
                end
            end
            StReq: begin
                mem_req_valid_o = 1'b1;
                cnt_d           = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d       = StIdle;
                    resp_fire     = 1'b1;
                    resp_err      = 1'b1;
                    arb_timeout_o = 1'b1;
                end else if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A real response in the timeout cycle takes precedence over the error.
                if (mem_resp_valid_i) begin
                    state_d   = StIdle;
                    resp_fire = 1'b1;
                    resp_data = mem_rdata_i;
                end else if (cnt_q == CntLast) begin
                    state_d       = StIdle;
                    resp_fire     = 1'b1;
                    resp_err      = 1'b1;
                    arb_timeout_o = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Keep every handshake and response quiet while reset is held.
        if (rst_i) begin
            ifu_req_ready_o = 1'b0;
            lsu_req_ready_o = 1'b0;
            mem_req_valid_o = 1'b0;
            arb_timeout_o   = 1'b0;
            resp_fire       = 1'b0;
            resp_err        = 1'b0;
            resp_data       = '0;
        end

        ifu_resp_valid_o = resp_fire && !owner_q;
        ifu_resp_err_o   = resp_fire && !owner_q && resp_err;
        ifu_rdata_o      = (resp_fire && !owner_q) ? resp_data : '0;
        lsu_resp_valid_o = resp_fire && owner_q;
        lsu_resp_err_o   = resp_fire && owner_q && resp_err;
        lsu_rdata_o      = (resp_fire && owner_q) ? resp_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            streak_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wen_o   = wen_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MW   = DW / 8;
    localparam int unsigned TMO  = 8;
    localparam int unsigned STRK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, arb_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TMO),
        .LSU_STREAK(STRK)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ifu_req_valid_i (ifu_req_valid),
        .ifu_req_ready_o (ifu_req_ready),
        .ifu_addr_i      (ifu_addr),
        .ifu_resp_valid_o(ifu_resp_valid),
        .ifu_rdata_o     (ifu_rdata),
        .ifu_resp_err_o  (ifu_resp_err),
        .lsu_req_valid_i (lsu_req_valid),
        .lsu_req_ready_o (lsu_req_ready),
        .lsu_addr_i      (lsu_addr),
        .lsu_wen_i       (lsu_wen),
        .lsu_wdata_i     (lsu_wdata),
        .lsu_wmask_i     (lsu_wmask),
        .lsu_resp_valid_o(lsu_resp_valid),
        .lsu_rdata_o     (lsu_rdata),
        .lsu_resp_err_o  (lsu_resp_err),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_addr_o      (mem_addr),
        .mem_wen_o       (mem_wen),
        .mem_wdata_o     (mem_wdata),
        .mem_wmask_o     (mem_wmask),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i     (mem_rdata),
        .arb_timeout_o   (arb_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected response, pushed at accept and popped when a response strobe appears.
    typedef struct {
        logic          is_lsu;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];

    // One table row: a single-requester transaction, memory behaviour, expected outcome.
    typedef struct {
        logic          is_lsu;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
        int            rdly;     // REQ cycles with mem_req_ready low
        int            respdly;  // WAIT cycles before mem_resp_valid, -1 = never
        logic [DW-1:0] mrdata;
        int            exp_lat;
        logic          exp_err;
        logic          exp_tmo;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam int NV = 8;
    vec_t tv[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_lsu, input logic [DW-1:0] rdata, input logic err,
                        input logic tmo, input int lat);
        exp_t e;
        e.is_lsu = is_lsu;
        e.rdata  = rdata;
        e.err    = err;
        e.tmo    = tmo;
        e.lat    = lat;
        e.acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the chosen requester to see ready; leaves time at that negedge.
    task automatic wait_accept(input logic want_lsu, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge clk);
            ok = want_lsu ? lsu_req_ready : ifu_req_ready;
            if (!ok) tick();
        end
        chk("accept", ok, 1'b1);
    endtask

    // Response monitor: checks every cycle, consumes scoreboard entries on response strobes.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_exclusive", ifu_req_ready & lsu_req_ready, 1'b0);
        chk("resp_exclusive", ifu_resp_valid & lsu_resp_valid, 1'b0);
        if (!ifu_resp_valid) chk("ifu_rdata_quiet", {ifu_rdata, ifu_resp_err}, '0);
        if (!lsu_resp_valid) chk("lsu_rdata_quiet", {lsu_rdata, lsu_resp_err}, '0);
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("resp_owner_lsu", lsu_resp_valid, e.is_lsu);
                chk("resp_rdata", e.is_lsu ? lsu_rdata : ifu_rdata, e.rdata);
                chk("resp_err", e.is_lsu ? lsu_resp_err : ifu_resp_err, e.err);
                chk("resp_timeout_pulse", arb_timeout, e.tmo);
                chk("resp_latency", cyc - e.acc, e.lat);
            end
        end else begin
            chk("timeout_pulse_quiet", arb_timeout, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t       v;
        logic       ok;
        logic [9:0] order;
        logic [AW-1:0] w_addr;
        int         resp_k;
        int         last;

        //          lsu   wen   addr          wdata         mask    rdly rsp mrdata     lat err tmo rdata
        tv[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 0,   0, 32'h13,        2, 1'b0, 1'b0, 32'h13};
        tv[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hA5A5_A5A5, 4'b0011, 3,  0, 32'h1234,      5, 1'b0, 1'b0, 32'h1234};
        tv[2] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,        4'b1111, 1,   2, 32'hCAFE_F00D, 5, 1'b0, 1'b0, 32'hCAFE_F00D};
        tv[3] = '{1'b1, 1'b0, 32'h8000_0020, 32'h0,        4'b1111, 0,   8, 32'hDEAD_0001, 8, 1'b1, 1'b1, 32'h0};
        tv[4] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0,        4'b0000, 0,   6, 32'h600D_F00D, 8, 1'b0, 1'b0, 32'h600D_F00D};
        tv[5] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,        4'b0000, 100, -1, 32'h0,        8, 1'b1, 1'b1, 32'h0};
        tv[6] = '{1'b0, 1'b0, 32'h8000_000C, 32'h0,        4'b0000, 2,   5, 32'h0BAD_BEEF, 8, 1'b1, 1'b1, 32'h0};
        tv[7] = '{1'b1, 1'b1, 32'h8000_0030, 32'h0102_0304, 4'b1100, 0,  1, 32'h0,         3, 1'b0, 1'b0, 32'h0};

        // Reset held with every input active: all outputs must stay 0.
        rst            = 1'b1;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h1111_1111;
        lsu_req_valid  = 1'b1;
        lsu_addr       = 32'h2222_2222;
        lsu_wen        = 1'b1;
        lsu_wdata      = 32'h3333_3333;
        lsu_wmask      = 4'hF;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, arb_timeout}, 3'b000);
        tick();
        rst            = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        lsu_wen        = 1'b0;

        // Both requesters valid every cycle: LSU streak of 4, then IFU.
        ifu_addr = 32'h8000_0100;
        lsu_addr = 32'h8000_2000;
        order    = '0;
        for (int g = 0; g < 10; g++) begin
            ok = 1'b0;
            for (int c = 0; c < 8 && !ok; c++) begin
                @(negedge clk);
                ok = ifu_req_ready | lsu_req_ready;
                if (!ok) tick();
            end
            chk("arb_accept", ok, 1'b1);
            if (!ok) break;
            order[g] = lsu_req_ready;
            w_addr   = lsu_req_ready ? lsu_addr : ifu_addr;
            push(lsu_req_ready, 32'h100 + g, 1'b0, 1'b0, 2);
            tick();
            mem_req_ready = 1'b1;
            @(negedge clk);
            chk("arb_mem_valid", mem_req_valid, 1'b1);
            chk("arb_mem_addr", mem_addr, w_addr);
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'h100 + g;
            tick();
            mem_resp_valid = 1'b0;
            mem_rdata      = '0;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk("arb_order", order, 10'b0111101111);

        // Single-requester transactions from the table.
        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            if (v.is_lsu) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = v.addr;
                lsu_wen       = v.wen;
                lsu_wdata     = v.wdata;
                lsu_wmask     = v.mask;
            end else begin
                ifu_req_valid = 1'b1;
                ifu_addr      = v.addr;
            end
            wait_accept(v.is_lsu, ok);
            if (ok) begin
                push(v.is_lsu, v.exp_rdata, v.exp_err, v.exp_tmo, v.exp_lat);
                tick();
                // Scramble request inputs so the latched copy is what gets checked.
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                ifu_addr      = ~v.addr;
                lsu_addr      = ~v.addr;
                lsu_wen       = ~v.wen;
                lsu_wdata     = ~v.wdata;
                lsu_wmask     = ~v.mask;
                resp_k = (v.respdly >= 0) ? v.rdly + v.respdly + 2 : 0;
                last   = (resp_k > v.exp_lat) ? resp_k : v.exp_lat;
                for (int k = 1; k <= last; k++) begin
                    mem_req_ready  = (k == v.rdly + 1);
                    mem_resp_valid = (k == resp_k);
                    mem_rdata      = mem_resp_valid ? v.mrdata : (32'h5A5A_0000 | k);
                    @(negedge clk);
                    if (k <= v.rdly + 1 && k <= v.exp_lat) begin
                        chk("req_mem_valid", mem_req_valid, 1'b1);
                        chk("req_mem_addr", mem_addr, v.addr);
                        chk("req_mem_wen", mem_wen, v.wen);
                        if (v.is_lsu) chk("req_mem_wdata_mask", {mem_wdata, mem_wmask},
                                          {v.wdata, v.mask});
                    end else if (k <= v.exp_lat) begin
                        chk("wait_mem_valid_low", mem_req_valid, 1'b0);
                    end else begin
                        chk("late_resp_dropped", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
                    end
                    tick();
                end
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                mem_rdata      = '0;
            end
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            chk("vec_resp_consumed", sb.size(), 0);
        end

        // Reset pulsed while waiting for memory: transaction abandoned, no response.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        wait_accept(1'b0, ok);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBEEF_0000;
        @(negedge clk);
        chk("rst_wait_no_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        chk("post_rst_mem", {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
        chk("post_rst_resp", {ifu_resp_valid, lsu_resp_valid, arb_timeout}, 3'b000);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0080;
        wait_accept(1'b0, ok);
        if (ok) push(1'b0, 32'h77, 1'b0, 1'b0, 2);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_req_addr", mem_addr, 32'h8000_0080);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h77;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        tick();
        @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
